pmod_cls_update_sequencer: RTL
==============================

# pmod_cls_update_sequencer

Sequences full-screen text updates to the Pmod CLS driver, sitting between application logic and the driver's command port. It accepts a two-line text update from one requester at any time, holds at most one pending update, and issues clear display, line 1 and line 2 to the driver in order, each under the driver's `command_ready` handshake. It also enforces a minimum interval between screen refreshes and reports coalesced (overwritten) updates and handshake timeouts.

## Interface
- `parm_min_interval_cycles`, default 4000000: clocks of holdoff after a completed sequence (100 ms at 40 MHz); must be ≥1.
- `parm_ack_timeout_cycles`, default 65536: maximum clocks to wait for each ready transition before aborting.
- `i_clk_40mhz` in 1: system clock.
- `i_rst_40mhz` in 1: reset, asynchronous, active-high.
- `i_update_valid` in 1: one-cycle strobe, capture `i_line1`/`i_line2` as an update.
- `i_line1`, `i_line2` in `t_pmod_cls_ascii_line_16`: text for the update.
- `o_busy` out 1: high whenever the state is not ST_IDLE or an update is pending.
- `o_seq_done` out 1: one-cycle pulse when the line-2 command completes.
- `o_drop_count` out 8: saturating count of pending updates overwritten before issue.
- `o_err_timeout` out 1: sticky flag, set on a handshake timeout; cleared only by reset.
- `i_cls_command_ready` in 1: driver `o_command_ready`.
- `o_cmd_wr_clear_display`, `o_cmd_wr_text_line1`, `o_cmd_wr_text_line2` out 1 each: one-cycle command strobes to the driver.
- `o_dat_ascii_line1`, `o_dat_ascii_line2` out `t_pmod_cls_ascii_line_16`: active text, stable for the entire sequence.

## Operation
- Storage: a pending slot (valid bit plus two lines) and an active buffer.
  - `i_update_valid` always writes the pending slot.
  - If the slot is already valid when written, the slot is overwritten and `o_drop_count` increments, saturating at 255.
- States: ST_IDLE, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_READY, ST_HOLDOFF. A 2-bit step register selects the command: 0 = clear, 1 = line 1, 2 = line 2.
- ST_IDLE, pending valid:
  - Copy pending to active.
  - Clear pending valid, unless `i_update_valid` is high in the same cycle. In that case the new data goes to pending and stays valid, with no drop counted.
  - Set step to 0 and go to ST_ISSUE.
- ST_ISSUE:
  - While `i_cls_command_ready` is 0, wait.
  - When it is 1, pulse the strobe for the current step for exactly one cycle, clear the timeout counter, and go to ST_WAIT_BUSY.
- ST_WAIT_BUSY:
  - Wait for `i_cls_command_ready` to be 0 (the driver's acknowledge), then clear the timeout counter and go to ST_WAIT_READY.
- ST_WAIT_READY:
  - Wait for `i_cls_command_ready` to be 1.
  - If step < 2: increment step and go to ST_ISSUE.
  - If step = 2: pulse `o_seq_done`, load the holdoff counter with `parm_min_interval_cycles`-1, and go to ST_HOLDOFF.
- Timeout: in ST_WAIT_BUSY or ST_WAIT_READY, if the counter reaches `parm_ack_timeout_cycles`-1 without the awaited transition:
  - Set `o_err_timeout`, go to ST_HOLDOFF, and do not assert `o_seq_done`.
  - The active update is discarded. Pending is kept.
- ST_HOLDOFF: count down to 0, then go to ST_IDLE. Updates arriving during holdoff go to pending only.
- Reset (asynchronous, including mid-sequence):
  - State ST_IDLE, step 0, all counters 0, pending invalid, buffers 0.
  - All outputs 0: strobes, `o_busy`, `o_seq_done`, `o_drop_count`, `o_err_timeout`, data lines.

## Timing
- All outputs are registered. Strobes are never asserted for more than one cycle and never asserted together.
- Latency from `i_update_valid` in ST_IDLE with ready = 1: pending is written in cycle N, ST_IDLE→ST_ISSUE at N+1, and `o_cmd_wr_clear_display` is high at N+2.
- `o_dat_ascii_line*` change only on the ST_IDLE→ST_ISSUE transition.
- Minimum gap from one `o_seq_done` to the next clear strobe: `parm_min_interval_cycles`+2 clocks.
- Ready bounce: ready high in the strobe cycle itself is not treated as completion; completion requires a 0 then a 1 after the strobe.
- Counters are wide enough for their parameter: `$clog2` of the parameter value plus 1 bit.

## Structure
- `t_pmod_cls_ascii_line_16` stays in `pmod_stand_spi_solo_pkg`.
- Add to that package: the `t_cls_seq_state` enum (the five states) and the `t_cls_seq_step` enum (CLEAR, LINE1, LINE2).
- One sub-module: `pmod_cls_pending_slot`, the one-deep overwrite buffer with its drop counter.

## Test plan
- Driver model with ready low for 20 cycles after each strobe; `parm_min_interval_cycles`=8; single update "HELLO"/"WORLD":
  - Required: clear, line 1 and line 2 strobes in that order, one cycle each.
  - Data stable throughout; `o_seq_done` once; `o_drop_count`=0.
- Three updates A, B, C issued during A's sequence:
  - Required: A is displayed, then C; `o_drop_count`=1.
  - Second sequence starts exactly 10 clocks after the first `o_seq_done`.
- Update arriving in the same cycle that pending is consumed:
  - Required: both updates are sequenced; no drop counted.
- Driver ready stuck at 1 after the line-1 strobe, `parm_ack_timeout_cycles`=16:
  - Required: `o_err_timeout`=1 at the 16th wait cycle; no line-2 strobe; no `o_seq_done`; sequencer returns to ST_IDLE after holdoff.
- Reset asserted in ST_WAIT_READY at step 1:
  - Required: all outputs 0 asynchronously; pending cleared; next update restarts from the clear command.
- 300 updates during a single sequence:
  - Required: `o_drop_count` saturates at 255.

Source files
------------

// File: rtl/pmod_stand_spi_solo_pkg.sv
// Shared types for the Pmod CLS text path: the 16-character line type
// plus the update sequencer's state and step encodings.
package pmod_stand_spi_solo_pkg;

  typedef logic [127:0] t_pmod_cls_ascii_line_16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_BUSY  = 3'd2,
    ST_WAIT_READY = 3'd3,
    ST_HOLDOFF    = 3'd4
  } t_cls_seq_state;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LINE1 = 2'd1,
    LINE2 = 2'd2
  } t_cls_seq_step;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/pmod_cls_update_sequencer_if.sv
// Application-side update port and driver-side command port of the
// update sequencer, bundled so the sequencer and its users share one view.
interface pmod_cls_update_sequencer_if;
  import pmod_stand_spi_solo_pkg::*;

  logic                    i_update_valid;
  t_pmod_cls_ascii_line_16 i_line1;
  t_pmod_cls_ascii_line_16 i_line2;
  logic                    o_busy;
  logic                    o_seq_done;
  logic [7:0]              o_drop_count;
  logic                    o_err_timeout;
  logic                    i_cls_command_ready;
  logic                    o_cmd_wr_clear_display;
  logic                    o_cmd_wr_text_line1;
  logic                    o_cmd_wr_text_line2;
  t_pmod_cls_ascii_line_16 o_dat_ascii_line1;
  t_pmod_cls_ascii_line_16 o_dat_ascii_line2;

  modport master (
    output i_update_valid, i_line1, i_line2, i_cls_command_ready,
    input  o_busy, o_seq_done, o_drop_count, o_err_timeout,
           o_cmd_wr_clear_display, o_cmd_wr_text_line1, o_cmd_wr_text_line2,
           o_dat_ascii_line1, o_dat_ascii_line2
  );

  modport slave (
    input  i_update_valid, i_line1, i_line2, i_cls_command_ready,
    output o_busy, o_seq_done, o_drop_count, o_err_timeout,
           o_cmd_wr_clear_display, o_cmd_wr_text_line1, o_cmd_wr_text_line2,
           o_dat_ascii_line1, o_dat_ascii_line2
  );

endinterface

// File: rtl/pmod_cls_pending_slot.sv
// One-deep overwrite buffer for screen updates; counts (saturating) every
// update that replaces one still waiting to be issued.
module pmod_cls_pending_slot
  import pmod_stand_spi_solo_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  t_pmod_cls_ascii_line_16 wr_line1,
  input  t_pmod_cls_ascii_line_16 wr_line2,
  input  logic                    consume,
  output logic                    valid,
  output t_pmod_cls_ascii_line_16 line1,
  output t_pmod_cls_ascii_line_16 line2,
  output logic [7:0]              drop_count
);

  // A write in the same cycle the sequencer takes the slot refills it without a drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= 1'b0;
      line1      <= '0;
      line2      <= '0;
      drop_count <= 8'd0;
    end else if (wr) begin
      valid <= 1'b1;
      line1 <= wr_line1;
      line2 <= wr_line2;
      if (valid && !consume) begin
        drop_count <= sat_inc8(drop_count);
      end
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pmod_cls_update_sequencer.sv
// Issues clear / line 1 / line 2 to the Pmod CLS driver under its ready
// handshake, with a refresh holdoff and a per-transition ack timeout.
module pmod_cls_update_sequencer
  import pmod_stand_spi_solo_pkg::*;
#(
  parameter int parm_min_interval_cycles = 4000000,
  parameter int parm_ack_timeout_cycles  = 65536
) (
  input logic                        i_clk_40mhz,
  input logic                        i_rst_40mhz,
  pmod_cls_update_sequencer_if.slave bus
);

  localparam int HOLD_W = $clog2(parm_min_interval_cycles) + 1;
  localparam int TO_W   = $clog2(parm_ack_timeout_cycles) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(parm_min_interval_cycles - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(parm_ack_timeout_cycles - 1);

  t_cls_seq_state          state;
  t_cls_seq_step           step;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [TO_W-1:0]         to_cnt;
  logic                    pend_valid;
  t_pmod_cls_ascii_line_16 pend_line1;
  t_pmod_cls_ascii_line_16 pend_line2;
  logic                    consume;
  logic                    next_idle;
  logic                    pend_valid_next;
  logic                    ready;
  logic                    clr_r, l1_r, l2_r, done_r, err_r, busy_r;
  t_pmod_cls_ascii_line_16 act_line1, act_line2;

  assign ready           = bus.i_cls_command_ready;
  assign consume         = (state == ST_IDLE) && pend_valid;
  assign pend_valid_next = bus.i_update_valid || (pend_valid && !consume);
  assign next_idle       = ((state == ST_IDLE) && !pend_valid) ||
                           ((state == ST_HOLDOFF) && (hold_cnt == '0));

  pmod_cls_pending_slot u_slot (
    .clk        (i_clk_40mhz),
    .rst        (i_rst_40mhz),
    .wr         (bus.i_update_valid),
    .wr_line1   (bus.i_line1),
    .wr_line2   (bus.i_line2),
    .consume    (consume),
    .valid      (pend_valid),
    .line1      (pend_line1),
    .line2      (pend_line2),
    .drop_count (bus.o_drop_count)
  );

  // Sequencer FSM; strobes and done are single-cycle registered pulses.
  always_ff @(posedge i_clk_40mhz or posedge i_rst_40mhz) begin
    if (i_rst_40mhz) begin
      state     <= ST_IDLE;
      step      <= CLEAR;
      hold_cnt  <= '0;
      to_cnt    <= '0;
      clr_r     <= 1'b0;
      l1_r      <= 1'b0;
      l2_r      <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      act_line1 <= '0;
      act_line2 <= '0;
    end else begin
      clr_r  <= 1'b0;
      l1_r   <= 1'b0;
      l2_r   <= 1'b0;
      done_r <= 1'b0;
      busy_r <= !next_idle || pend_valid_next;
      case (state)
        ST_IDLE: begin
          if (pend_valid) begin
            act_line1 <= pend_line1;
            act_line2 <= pend_line2;
            step      <= CLEAR;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ready) begin
            case (step)
              CLEAR:   clr_r <= 1'b1;
              LINE1:   l1_r  <= 1'b1;
              default: l2_r  <= 1'b1;
            endcase
            to_cnt <= '0;
            state  <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (!ready) begin
            to_cnt <= '0;
            state  <= ST_WAIT_READY;
          end else if (to_cnt == TO_LAST) begin
            err_r    <= 1'b1;
            hold_cnt <= HOLD_LOAD;
            state    <= ST_HOLDOFF;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_WAIT_READY: begin
          if (ready) begin
            if (step == LINE2) begin
              done_r   <= 1'b1;
              hold_cnt <= HOLD_LOAD;
              state    <= ST_HOLDOFF;
            end else begin
              step  <= (step == CLEAR) ? LINE1 : LINE2;
              state <= ST_ISSUE;
            end
          end else if (to_cnt == TO_LAST) begin
            err_r    <= 1'b1;
            hold_cnt <= HOLD_LOAD;
            state    <= ST_HOLDOFF;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_cmd_wr_clear_display = clr_r;
  assign bus.o_cmd_wr_text_line1    = l1_r;
  assign bus.o_cmd_wr_text_line2    = l2_r;
  assign bus.o_seq_done             = done_r;
  assign bus.o_err_timeout          = err_r;
  assign bus.o_busy                 = busy_r;
  assign bus.o_dat_ascii_line1      = act_line1;
  assign bus.o_dat_ascii_line2      = act_line2;

endmodule
